// File: rtl/ncc_window_ctrl.sv
// Double-buffered fill controller for the NCC search-window row BRAMs.
// Scatters a raster pixel stream into per-row BRAMs and hands full banks to the correlator.
module ncc_window_ctrl #(
    parameter int ROWS = 16,
    parameter int COLS = 80,
    parameter int AW   = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [7:0]      pix_in,
    input  logic            pix_valid,
    output logic            pix_ready,
    output logic [ROWS-1:0] wr_en,
    output logic [AW-1:0]   wr_addr,
    output logic [7:0]      wr_data,
    output logic            win_ready,
    output logic            win_bank,
    input  logic            win_release,
    output logic            busy,
    output logic [15:0]     windows_done
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = AW - 1;
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

    typedef enum logic [1:0] {IDLE, FILL, COMMIT} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_fill_bank;
    logic            r_cons_bank;
    logic [1:0]      r_full;
    logic [1:0]      w_full_nxt;
    logic [RW-1:0]   r_row;
    logic [CW-1:0]   r_col;
    logic [ROWS-1:0] r_wr_en;
    logic [AW-1:0]   r_wr_addr;
    logic [7:0]      r_wr_data;
    logic [15:0]     r_windows_done;

    logic w_accept;
    logic w_last;
    logic w_start_ok;
    logic w_release_ok;

    assign w_accept     = (r_state == FILL) && pix_valid;
    assign w_last       = (r_row == ROW_LAST) && (r_col == COL_LAST);
    assign w_start_ok   = start && !r_full[r_fill_bank];
    assign w_release_ok = win_release && r_full[r_cons_bank];

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_start_ok) w_state_nxt = FILL;
            FILL:    if (w_accept && w_last) w_state_nxt = COMMIT;
            COMMIT:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Commit and release never target the same bank, so both updates apply.
    always_comb begin
        w_full_nxt = r_full;
        if (r_state == COMMIT) w_full_nxt[r_fill_bank] = 1'b1;
        if (w_release_ok)      w_full_nxt[r_cons_bank] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fill_bank    <= 1'b0;
            r_cons_bank    <= 1'b0;
            r_full         <= 2'b00;
            r_row          <= '0;
            r_col          <= '0;
            r_wr_en        <= '0;
            r_wr_addr      <= '0;
            r_wr_data      <= '0;
            r_windows_done <= '0;
        end else begin
            r_wr_en <= '0;
            if ((r_state == IDLE) && w_start_ok) begin
                r_row <= '0;
                r_col <= '0;
            end else if (w_accept) begin
                r_wr_en   <= ROWS'(1) << r_row;
                r_wr_addr <= {r_fill_bank, r_col};
                r_wr_data <= pix_in;
                if (r_col == COL_LAST) begin
                    r_col <= '0;
                    r_row <= r_row + RW'(1);
                end else begin
                    r_col <= r_col + CW'(1);
                end
            end
            if (r_state == COMMIT) begin
                r_fill_bank    <= ~r_fill_bank;
                r_windows_done <= r_windows_done + 16'd1;
            end
            if (w_release_ok) r_cons_bank <= ~r_cons_bank;
            r_full <= w_full_nxt;
        end
    end

    assign pix_ready    = (r_state == FILL);
    assign busy         = (r_state != IDLE);
    assign wr_en        = r_wr_en;
    assign wr_addr      = r_wr_addr;
    assign wr_data      = r_wr_data;
    assign win_ready    = r_full[r_cons_bank];
    assign win_bank     = r_cons_bank;
    assign windows_done = r_windows_done;

endmodule
